// File: rtl/strait_test_ctrl_if.sv
// Scan-chain test controller bus: pattern/operand outputs toward the PE array and
// run handshake. The sig member exists only when STRAIT_SIG_DUMP_EN is defined.
interface strait_test_ctrl_if;
    logic        start;
    logic [31:0] scan_in;
    logic        scan_en;
    logic [31:0] scan_out;
    logic [31:0] a_out;
    logic [31:0] w_out;
    logic        busy;
    logic        done;
    logic        pass;
`ifdef STRAIT_SIG_DUMP_EN
    logic [31:0] sig;
`endif

    modport master (
        output start,
        output scan_in,
        input  scan_en,
        input  scan_out,
        input  a_out,
        input  w_out,
        input  busy,
        input  done,
        input  pass
`ifdef STRAIT_SIG_DUMP_EN
        , input sig
`endif
    );

    modport slave (
        input  start,
        input  scan_in,
        output scan_en,
        output scan_out,
        output a_out,
        output w_out,
        output busy,
        output done,
        output pass
`ifdef STRAIT_SIG_DUMP_EN
        , output sig
`endif
    );
endinterface

// File: rtl/strait_test_ctrl.sv
// LFSR-driven scan test controller with MISR signature compaction for a PE chain.
// Define STRAIT_SIG_DUMP_EN to expose the live MISR on bus.sig.
module strait_test_ctrl #(
    parameter int          CHAIN_LEN = 4,
    parameter int          NUM_PAT   = 8,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter logic [31:0] GOLDEN    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    strait_test_ctrl_if.slave bus
);

    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [6:0]  CNT_LAST  = 7'(CHAIN_LEN - 1);
    localparam logic [7:0]  PAT_TOTAL = 8'(NUM_PAT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Galois right-shift step shared by the pattern generator and the MISR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0000_0000);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] misr_q, misr_d;
    logic [7:0]  pat_q, pat_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        scan_en_q, scan_en_d;
    logic [31:0] scan_out_q, scan_out_d;
    logic [31:0] a_out_q, a_out_d;
    logic [31:0] w_out_q, w_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    // Next-state, LFSR/MISR and counter logic.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SHIFT_IN;
                    lfsr_d  = SEED;
                    misr_d  = 32'h0000_0000;
                    pat_d   = 8'd0;
                    cnt_d   = 7'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            SHIFT_IN: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            CAPTURE: begin
                lfsr_d  = lfsr_step(lfsr_q);
                cnt_d   = 7'd0;
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                misr_d = lfsr_step(misr_q) ^ bus.scan_in;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 7'd0;
                    pat_d = pat_q + 8'd1;
                    if (pat_d < PAT_TOTAL) begin
                        state_d = SHIFT_IN;
                    end else begin
                        // Verdict uses the signature including this final shift.
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (misr_d == GOLDEN);
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values are derived from the upcoming state so they line up with it.
    always_comb begin
        scan_en_d  = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
        busy_d     = (state_d == SHIFT_IN) || (state_d == CAPTURE) || (state_d == SHIFT_OUT);
        scan_out_d = (state_d == SHIFT_IN) ? lfsr_d : 32'h0000_0000;
        if (state_d == CAPTURE) begin
            a_out_d = lfsr_d;
            w_out_d = {lfsr_d[15:0], lfsr_d[31:16]};
        end else begin
            a_out_d = 32'h0000_0000;
            w_out_d = 32'h0000_0000;
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            misr_q     <= 32'h0000_0000;
            pat_q      <= 8'd0;
            cnt_q      <= 7'd0;
            scan_en_q  <= 1'b0;
            scan_out_q <= 32'h0000_0000;
            a_out_q    <= 32'h0000_0000;
            w_out_q    <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            scan_en_q  <= scan_en_d;
            scan_out_q <= scan_out_d;
            a_out_q    <= a_out_d;
            w_out_q    <= w_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.scan_en  = scan_en_q;
    assign bus.scan_out = scan_out_q;
    assign bus.a_out    = a_out_q;
    assign bus.w_out    = w_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
`ifdef STRAIT_SIG_DUMP_EN
    assign bus.sig      = misr_q;
`endif

endmodule

// File: tb/tb_strait_test_ctrl.sv
// Self-checking bench for strait_test_ctrl: vector table, model-checked random runs,
// restart/ignore-start, mid-run reset and a short-chain signature case.
module tb_strait_test_ctrl;

    localparam int CL  = 4;
    localparam int NP  = 8;
    localparam int RUN = NP * (2 * CL + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strait_test_ctrl_if if0 ();
    strait_test_ctrl_if if1 ();
    strait_test_ctrl_if if2 ();

    assign if1.start   = if0.start;
    assign if1.scan_in = if0.scan_in;

    strait_test_ctrl #(.CHAIN_LEN(CL), .NUM_PAT(NP), .SEED(32'h0000_0001), .GOLDEN(32'h0000_0000))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    strait_test_ctrl #(.CHAIN_LEN(CL), .NUM_PAT(NP), .SEED(32'h0000_0001), .GOLDEN(32'h0000_0001))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    strait_test_ctrl #(.CHAIN_LEN(2), .NUM_PAT(1), .SEED(32'h0000_0001), .GOLDEN(32'h8020_0003))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] seq [NP * (CL + 1)];

    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1 ({tag, ".scan_en"}, if0.scan_en, 1'b0);
        chk32({tag, ".scan_out"}, if0.scan_out, 32'h0);
        chk32({tag, ".a_out"}, if0.a_out, 32'h0);
        chk32({tag, ".w_out"}, if0.w_out, 32'h0);
        chk1 ({tag, ".busy"}, if0.busy, 1'b0);
        chk1 ({tag, ".done"}, if0.done, 1'b0);
        chk1 ({tag, ".pass"}, if0.pass, 1'b0);
    endtask

    // Full run on u0/u1 checked cycle by cycle against the schedule model.
    // mode 0: scan_in=0, mode 1: random scan_in. start_at: cycle to pulse start (0 = none).
    task automatic run(input int mode, input int start_at);
        logic [31:0] misr;
        misr = 32'h0;
        @(negedge clk);
        if0.start   = 1'b1;
        if0.scan_in = 32'h0;
        for (int n = 1; n <= RUN + 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            if0.start = 1'b0;
            if (n <= RUN) begin
                int t, p, ph;
                logic [31:0] e_so, e_a;
                t  = n - 1;
                p  = t / (2 * CL + 1);
                ph = t % (2 * CL + 1);
                e_so = (ph < CL)  ? seq[p * (CL + 1) + ph] : 32'h0;
                e_a  = (ph == CL) ? seq[p * (CL + 1) + CL] : 32'h0;
                chk1 ("run.scan_en", if0.scan_en, (ph != CL));
                chk32("run.scan_out", if0.scan_out, e_so);
                chk32("run.a_out", if0.a_out, e_a);
                chk32("run.w_out", if0.w_out, {e_a[15:0], e_a[31:16]});
                chk1 ("run.busy", if0.busy, 1'b1);
                chk1 ("run.done", if0.done, 1'b0);
                chk1 ("run.pass", if0.pass, 1'b0);
`ifdef STRAIT_SIG_DUMP_EN
                chk32("run.sig", if0.sig, misr);
`endif
                if0.scan_in = (mode == 1) ? $urandom : 32'h0;
                if (ph > CL) misr = step(misr) ^ if0.scan_in;
                if (n == start_at) if0.start = 1'b1;
            end else begin
                chk1 ("end.done", if0.done, 1'b1);
                chk1 ("end.busy", if0.busy, 1'b0);
                chk1 ("end.scan_en", if0.scan_en, 1'b0);
                chk1 ("end.pass", if0.pass, (misr == 32'h0));
                chk1 ("end.u1_done", if1.done, 1'b1);
                chk1 ("end.u1_pass", if1.pass, (misr == 32'h1));
`ifdef STRAIT_SIG_DUMP_EN
                chk32("end.sig", if0.sig, misr);
`endif
            end
        end
        if0.scan_in = 32'h0;
    endtask

    typedef struct {
        logic        start;
        logic [31:0] scan_in;
        logic        en;
        logic [31:0] so;
        logic [31:0] a;
        logic [31:0] w;
        logic        busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        rst = 1'b0;
        if0.start = 1'b0; if0.scan_in = 32'h0;
        if2.start = 1'b0; if2.scan_in = 32'h0;
        seq[0] = 32'h0000_0001;
        for (int i = 1; i < NP * (CL + 1); i++) seq[i] = step(seq[i - 1]);

        // First pattern of a run, cycle by cycle; start in row 6 lands in SHIFT_OUT.
        tbl[0] = '{1'b1, 32'h0, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 32'h8020_0003, 32'h0, 32'h0, 1'b1};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 32'hC030_0002, 32'h0, 32'h0, 1'b1};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 32'h6018_0001, 32'h0, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'hB02C_0003, 32'h0003_B02C, 1'b1};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1};
        tbl[6] = '{1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 32'hD836_0002, 32'h0, 32'h0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("idle");

        // Table-driven first pattern, then finish the run checking done timing.
        for (int i = 0; i < 10; i++) begin
            if0.start   = tbl[i].start;
            if0.scan_in = tbl[i].scan_in;
            @(posedge clk);
            @(negedge clk);
            chk1 ($sformatf("tbl%0d.scan_en", i), if0.scan_en, tbl[i].en);
            chk32($sformatf("tbl%0d.scan_out", i), if0.scan_out, tbl[i].so);
            chk32($sformatf("tbl%0d.a_out", i), if0.a_out, tbl[i].a);
            chk32($sformatf("tbl%0d.w_out", i), if0.w_out, tbl[i].w);
            chk1 ($sformatf("tbl%0d.busy", i), if0.busy, tbl[i].busy);
        end
        if0.start = 1'b0;
        for (int n = 11; n <= RUN + 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk1("tbl.done_timing", if0.done, (n == RUN + 1));
        end
        chk1("tbl.pass_golden0", if0.pass, 1'b1);
        chk1("tbl.pass_golden1", if1.pass, 1'b0);

        // Restart from DONE, then random runs with an ignored start in SHIFT_OUT.
        run(0, 0);
        run(1, 7);
        run(1, 0);
        run(1, 40);

        // Reset asserted during CAPTURE clears outputs without a clock edge.
        @(negedge clk);
        if0.start = 1'b1;
        for (int n = 1; n <= CL + 1; n++) begin
            @(posedge clk);
            @(negedge clk);
            if0.start = 1'b0;
        end
        chk32("pre_rst.a_out", if0.a_out, 32'hB02C_0003);
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all_zero("post_rst_idle");

        // Short chain: a single 1 in the first SHIFT_OUT cycle yields signature 8020_0003.
        if2.start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            if2.start   = 1'b0;
            if2.scan_in = (n == 4) ? 32'h1 : 32'h0;
            chk1("u2.done", if2.done, (n == 6));
        end
        chk1("u2.pass", if2.pass, 1'b1);
`ifdef STRAIT_SIG_DUMP_EN
        chk32("u2.sig", if2.sig, 32'h8020_0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
